// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: default widths, NOP encoding, fetch FSM states
// and the instruction field positions decode relies on.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned INSTR_W_DEF = 16;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned IMMF_BIT = 11;
    localparam int unsigned RD_MSB   = 10;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned RS1_MSB  = 7;
    localparam int unsigned RS1_LSB  = 5;
    localparam int unsigned RS2_MSB  = 4;
    localparam int unsigned RS2_LSB  = 0;

    function automatic logic [3:0] opcode_of(input logic [15:0] i_instr);
        return i_instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries with push, pop, clear and occupancy count.
module fetch_queue #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !i_clear)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch: PC, single-outstanding imem requests, in-order instruction queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter int unsigned       QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               is_branch_taken,
    input  logic [ADDR_W-1:0]  branch_target_in,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e               r_state;
    logic [ADDR_W-1:0]          r_pc;
    logic [ADDR_W-1:0]          r_req_addr;

    logic [CNT_W-1:0]           w_count;
    logic                       w_q_empty;
    logic [ADDR_W+INSTR_W-1:0]  w_q_head;
    logic [ADDR_W-1:0]          w_head_pc;
    logic [INSTR_W-1:0]         w_head_instr;
    logic [ADDR_W-1:0]          w_replay_pc;
    logic                       w_redirect;
    logic                       w_can_req;
    logic                       w_accept;
    logic                       w_bypass;
    logic                       w_push;
    logic                       w_pop;

    assign w_redirect                = flush | is_branch_taken;
    assign {w_head_pc, w_head_instr} = w_q_head;

    // The in-flight slot is reserved so a returning response always has room.
    assign w_can_req = (w_count + CNT_W'(r_state == WAIT)) < CNT_W'(QDEPTH);
    assign imem_req  = !reset && (r_state == IDLE) && w_can_req && !w_redirect;
    assign imem_addr = r_pc;
    assign w_accept  = imem_req && imem_ready;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = !reset && w_q_empty && (r_state == WAIT) && imem_rvalid && !w_redirect;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = (r_state == WAIT) && imem_rvalid && !w_redirect && !(w_bypass && !stall);
    assign w_pop  = !w_q_empty && !stall && !w_redirect;

    always_comb begin
        w_replay_pc = r_pc;
        if (!w_q_empty)
            w_replay_pc = w_head_pc;
        else if (r_state != IDLE)
            w_replay_pc = r_req_addr;
    end

    always_comb begin
        instr       = INSTR_W'(NOP_INSTR);
        instr_pc    = '0;
        instr_valid = 1'b0;
        if (!reset) begin
            if (!w_q_empty) begin
                instr       = w_head_instr;
                instr_pc    = w_head_pc;
                instr_valid = 1'b1;
            end else if (w_bypass) begin
                instr       = imem_rdata;
                instr_pc    = r_req_addr;
                instr_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= is_branch_taken ? branch_target_in : w_replay_pc;
            // A response still owed from WAIT or DROP must be swallowed later.
            r_state <= ((r_state != IDLE) && !imem_rvalid) ? DROP : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_addr <= r_pc;
                        r_pc       <= r_pc + 1'b1;
                        r_state    <= WAIT;
                    end
                end
                WAIT: if (imem_rvalid) r_state <= IDLE;
                DROP: if (imem_rvalid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .W     (ADDR_W + INSTR_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_req_addr, imem_rdata}),
        .o_rdata (w_q_head),
        .o_count (w_count),
        .o_empty (w_q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked against
// an in-order PC stream model and a single-outstanding memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        is_branch_taken;
    logic [15:0] branch_target_in;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;

    int checks     = 0;
    int errors     = 0;
    int deliveries = 0;

    int mem_lat  = 2;
    bit mem_rand = 1'b0;

    logic [15:0] exp_pc       = 16'h0000;
    bit          novalid_next = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .QDEPTH   (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .is_branch_taken  (is_branch_taken),
        .branch_target_in (branch_target_in),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {4'h1, a[11:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accept(input string tag, output logic [15:0] addr);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req && imem_ready) && n < 60);
        chk({tag, "_accept"}, 32'(imem_req && imem_ready), 1);
        addr = imem_addr;
    endtask

    task automatic wait_valid(input string tag, output logic [15:0] pc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 60);
        chk({tag, "_valid"}, 32'(instr_valid), 1);
        pc = instr_pc;
    endtask

    // Memory: one request at a time, answered in order after a per-request latency.
    bit          pend_valid = 1'b0;
    logic [15:0] pend_addr  = '0;
    int          pend_cnt   = 0;
    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_valid = 1'b0;
            end else if (imem_req && imem_ready) begin
                chk("single_outstanding", 32'(pend_valid), 0);
                pend_valid = 1'b1;
                pend_addr  = imem_addr;
                pend_cnt   = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            end else if (imem_rvalid) begin
                pend_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pend_valid && pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                end
            end
            imem_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Decode-side view: consumed PCs form a consecutive run restarted by redirects.
    always @(negedge clk) begin
        if (reset) begin
            exp_pc       = 16'h0000;
            novalid_next = 1'b0;
        end else begin
            if (novalid_next)
                chk("bubble_after_redirect", 32'(instr_valid), 0);
            novalid_next = is_branch_taken || flush;
            if (is_branch_taken || flush)
                chk("no_req_on_redirect", 32'(imem_req), 0);
            if (is_branch_taken) begin
                exp_pc = branch_target_in;
            end else if (!flush && instr_valid) begin
                chk("stream_pc", 32'(instr_pc), 32'(exp_pc));
                chk("stream_instr", 32'(instr), 32'(mem_word(exp_pc)));
                if (!stall) begin
                    exp_pc = exp_pc + 16'd1;
                    deliveries++;
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        int          n;
        int          since_br;
        int          base_del;
        int unsigned r;

        reset            = 1'b1;
        stall            = 1'b0;
        flush            = 1'b0;
        is_branch_taken  = 1'b0;
        branch_target_in = '0;

        // Reset state and first-fetch latency
        @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_pc", 32'(instr_pc), 0);
        chk("rst_req", 32'(imem_req), 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", 32'(imem_addr), 32'h0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 20);
`ifdef FETCH_BYPASS_EN
        chk("first_latency", 32'(n), 2);
`else
        chk("first_latency", 32'(n), 3);
`endif
        for (int k = 1; k < 4; k++) begin
            wait_valid("basic", a);
            chk("basic_pc", 32'(a), 32'(k));
        end

        // Stall fill from a fresh reset
        step();
        reset = 1'b1;
        stall = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (20) step();
        @(negedge clk);
        chk("fill_req_blocked", 32'(imem_req), 0);
        chk("fill_valid", 32'(instr_valid), 1);
        chk("fill_head_pc", 32'(instr_pc), 32'h0000);
        chk("fill_head_instr", 32'(instr), 32'h1000);
        step();
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_valid", 32'(instr_valid), 1);
            chk("drain_pc", 32'(instr_pc), 32'(k));
        end

        // Branch while a fetch is in flight
        mem_lat = 3;
        wait_accept("br", a);
        step();
        is_branch_taken  = 1'b1;
        branch_target_in = 16'h0008;
        step();
        is_branch_taken = 1'b0;
        wait_accept("br_next", a);
        chk("br_addr", 32'(a), 32'h0008);
        wait_valid("br_deliver", a);
        chk("br_pc", 32'(a), 32'h0008);

        // Flush replays from the queue head
        step();
        stall            = 1'b1;
        is_branch_taken  = 1'b1;
        branch_target_in = 16'h0005;
        step();
        is_branch_taken = 1'b0;
        wait_valid("fl_head", a);
        chk("fl_head_pc", 32'(a), 32'h0005);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_accept("fl_next", a);
        chk("fl_addr", 32'(a), 32'h0005);
        step();
        stall = 1'b0;
        wait_valid("fl_deliver", a);
        chk("fl_pc", 32'(a), 32'h0005);

        // Address wrap
        step();
        is_branch_taken  = 1'b1;
        branch_target_in = 16'hFFFE;
        step();
        is_branch_taken = 1'b0;
        wait_valid("wrap0", a);
        chk("wrap_pc0", 32'(a), 32'hFFFE);
        wait_valid("wrap1", a);
        chk("wrap_pc1", 32'(a), 32'hFFFF);
        wait_valid("wrap2", a);
        chk("wrap_pc2", 32'(a), 32'h0000);

        // Branch beats flush, and a same-cycle response is discarded
        mem_lat = 2;
        wait_accept("prio", a);
        n = 0;
        do begin
            step();
            n++;
        end while (!imem_rvalid && n < 10);
        chk("prio_rvalid_seen", 32'(imem_rvalid), 1);
        flush            = 1'b1;
        is_branch_taken  = 1'b1;
        branch_target_in = 16'h0020;
        step();
        flush           = 1'b0;
        is_branch_taken = 1'b0;
        wait_accept("prio_next", a);
        chk("prio_addr", 32'(a), 32'h0020);
        wait_valid("prio_deliver", a);
        chk("prio_pc", 32'(a), 32'h0020);

        // Reset while waiting on memory
        wait_accept("rstw", a);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_valid0", 32'(instr_valid), 0);
        step();
        @(negedge clk);
        chk("rstw_valid1", 32'(instr_valid), 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_valid2", 32'(instr_valid), 0);
        chk("rstw_req", 32'(imem_req), 1);
        chk("rstw_addr", 32'(imem_addr), 32'h0000);

        // Randomized traffic
        mem_rand = 1'b1;
        since_br = 0;
        base_del = deliveries;
        for (int c = 0; c < 1500; c++) begin
            step();
            r                = $urandom_range(0, 99);
            stall            = ($urandom_range(0, 9) < 3);
            is_branch_taken  = (r < 3);
            flush            = (r >= 3 && r < 6 && since_br > 6);
            branch_target_in = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            since_br         = is_branch_taken ? 0 : since_br + 1;
        end
        step();
        stall           = 1'b0;
        flush           = 1'b0;
        is_branch_taken = 1'b0;
        mem_rand        = 1'b0;
        repeat (30) step();
        chk("random_progress", 32'(deliveries - base_del > 80), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage that directly feeds decode_unit in the 16-bit superscalar core.
- Holds the PC and issues one-at-a-time requests to instruction memory.
- Buffers returned 16-bit instructions in a small queue and presents them in order to decode.
- Honours decode's stall, flush and is_branch_taken/branch_target_in redirect signals.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width (word addressed, one instruction per word).
- INSTR_W, 16, instruction width.
- QDEPTH, 4, instruction queue entries (power of two, >= 2).
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  in  1  clock; synchronous, active-high reset.
- reset  in  1  synchronous active-high reset.
- stall  in  1  decode cannot accept this cycle.
- flush  in  1  discard queue and in-flight fetch; replay from the oldest discarded PC.
- is_branch_taken  in  1  redirect to branch_target_in.
- branch_target_in  in  ADDR_W  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; in order, at the earliest 1 cycle after acceptance.
- imem_rdata  in  INSTR_W  response data.
- instr  out  INSTR_W  instruction to decode.
- instr_pc  out  ADDR_W  PC of instr.
- instr_valid  out  1  instr is valid.

Behaviour:
- Reset:
  - pc=RESET_PC; FSM=IDLE; queue empty.
  - instr=16'h0000 (NOP), instr_pc=0, instr_valid=0, imem_req=0.
  - A reset mid-operation abandons any outstanding request; the memory shares the same reset.
- FSM:
  - IDLE: imem_req=1 when count < QDEPTH and neither flush nor is_branch_taken is asserted; imem_addr=pc. On acceptance (req&ready): latch req_addr=pc, pc=pc+1 (wraps FFFF->0000), go to WAIT.
  - WAIT: on imem_rvalid, push {req_addr, imem_rdata} and go to IDLE. The request is not reissued in the same cycle.
  - DROP: entered on redirect while WAIT with no rvalid that cycle. On rvalid, discard the data and go to IDLE. No requests are issued in DROP.
- Queue:
  - Head drives instr/instr_pc; instr_valid = !empty.
  - Pop when instr_valid & !stall.
  - Push and pop may occur in the same cycle.
  - Request gating counts the in-flight slot: a request is issued only if count + (FSM==WAIT) < QDEPTH, so a push never overflows.
- Redirect:
  - is_branch_taken: clear queue, pc=branch_target_in. FSM goes to DROP if WAIT without rvalid, otherwise IDLE.
  - flush without is_branch_taken: same clear/drop, but pc = replay_pc, where replay_pc is the first of these that applies:
    - head PC if the queue is non-empty;
    - else req_addr if in WAIT/DROP;
    - else pc.
  - is_branch_taken has priority over flush; both have priority over stall, push and pop.
  - An rvalid arriving in the redirect cycle is discarded.
  - instr_valid=0 in the cycle after any redirect.
- Latency:
  - First request in the first cycle after reset deasserts.
  - Memory latency L means instr_valid rises L+1 cycles after acceptance.
  - Peak throughput is 1 instruction per (L+1) cycles (single outstanding request).
- While stall is held, instr/instr_pc remain stable.

Optional Feature:
- FETCH_BYPASS_EN
  - Defined: when the queue is empty, FSM is WAIT, imem_rvalid=1 and no redirect, the response drives instr/instr_pc/instr_valid combinationally that cycle. If !stall it is consumed without a push; if stall it is pushed. This saves 1 cycle of latency.
  - Undefined: every response passes through the queue, giving a fixed L+1 latency.

Decomposition:
- fetch_pkg holds:
  - ADDR_W and INSTR_W defaults;
  - NOP_INSTR=16'h0000;
  - FSM state encoding {IDLE, WAIT, DROP};
  - instruction field positions shared with decode: opcode[15:12], imm-flag[11], rd[10:8], rs1[7:5], rs2/imm[4:0].
- One sub-module, fetch_queue: synchronous FIFO with push, pop, clear, count, and head data; it stores {pc, instr}.

Test Plan:
- Basic fetch:
  - Stimulus: reset for 2 cycles; memory with ready=1, L=2, rdata={4'h1,addr[11:0]}; stall=0.
  - Response: instr_pc sequence 0000,0001,0002,0003 with instr 1000..1003. First instr_valid 3 cycles after the first accept (2 with FETCH_BYPASS_EN).
- Stall fill:
  - Stimulus: stall=1 for 20 cycles.
  - Response: queue holds 0000..0003; imem_req stays 0 once 4 entries are queued or in flight; instr holds 1000. After stall drops, PCs 0000..0003 appear on consecutive cycles.
- Branch during in-flight fetch:
  - Stimulus: is_branch_taken=1, branch_target_in=0008 while in WAIT.
  - Response: instr_valid=0 next cycle; the stale response is dropped; next imem_addr=0008; the next delivered instr_pc is 0008.
- Flush replay:
  - Stimulus: flush=1 with head instr_pc=0005.
  - Response: queue cleared; the next imem_addr is 0005; delivery resumes at 0005.
- Wrap:
  - Stimulus: branch to FFFE.
  - Response: delivered PCs FFFE, FFFF, 0000.
- Priority and reset:
  - Stimulus: flush=1, is_branch_taken=1 (target 0020) and imem_rvalid=1 in the same cycle.
  - Response: data discarded; the next request is to 0020.
  - Then: reset asserted in WAIT leaves instr_valid=0, and the next imem_addr is 0000.
